// File: rtl/frame_pkg.sv
// Shared types for the dual-rail frame scheduler: FSM states, token indices,
// the fixed token value table and the per-frame context payload.
package frame_pkg;

  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned NUM_TOK   = 5;
  localparam int unsigned TOK_IDX_W = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_TOK_SET,
    ST_WAIT_HI,
    ST_TOK_CLR,
    ST_WAIT_LO,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef logic [TOK_IDX_W-1:0] tok_idx_t;

  localparam tok_idx_t TOK_FS  = 3'd0;
  localparam tok_idx_t TOK_CH  = 3'd1;
  localparam tok_idx_t TOK_X0  = 3'd2;
  localparam tok_idx_t TOK_DIR = 3'd3;
  localparam tok_idx_t TOK_FE  = 3'd4;

  // Values of the fixed-position tokens; bit i is token i (CH and DIR are per frame)
  localparam logic [NUM_TOK-1:0] TOK_TABLE = 5'b10001;

  typedef struct packed {
    logic     ch;
    logic     dir;
    tok_idx_t idx;
  } frame_ctx_t;

  function automatic logic token_value(input tok_idx_t idx, input logic ch, input logic dir);
    logic v;
    v = 1'b0;
    case (idx)
      TOK_CH:                 v = ch;
      TOK_DIR:                v = dir;
      TOK_FS, TOK_X0, TOK_FE: v = TOK_TABLE[idx];
      default:                v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/frame_scheduler_ack_sync.sv
// Multi-flop synchronizer for the asynchronous four-phase ack; resets to 0.
module ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/frame_scheduler.sv
// Round-robin two-channel scheduler emitting five-token dual-rail frames over a
// four-phase ack handshake. Define ACK_TIMEOUT_EN to build the ack-wait timeout.
module frame_scheduler
  import frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] dir,
  output logic [NUM_CH-1:0] grant,
  input  logic              ack,
  output logic              bit0_out,
  output logic              bit1_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("frame_scheduler: SYNC_STAGES must be 2..3 and TIMEOUT_CYCLES >= 1");
  end

  state_e            state_q, state_d;
  frame_ctx_t        ctx_q, ctx_d;
  logic              prio_q, prio_d;
  logic [NUM_CH-1:0] grant_d;
  logic              busy_d, done_d, err_d, bit0_d, bit1_d;
  logic              ack_s;
  logic              tmo_hit;
  logic              ch_pick;
  logic              tok_c;

  ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ack),
    .q       (ack_s)
  );

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;

  // Counts cycles spent in the current wait state; cleared on every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else if ((state_q == state_d) &&
                 (state_q == ST_WAIT_HI || state_q == ST_WAIT_LO)) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end else begin
      tmo_q <= '0;
    end
  end

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus next values of the registered outputs and frame context
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    prio_d  = prio_q;
    grant_d = '0;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bit0_d  = bit0_out;
    bit1_d  = bit1_out;
    ch_pick = 1'b0;
    tok_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          ch_pick   = (&req) ? prio_q : req[1];
          state_d   = ST_ARB;
          grant_d   = ch_pick ? 2'b10 : 2'b01;
          ctx_d.ch  = ch_pick;
          ctx_d.dir = dir[ch_pick];
          ctx_d.idx = TOK_FS;
          prio_d    = ~ch_pick;
          busy_d    = 1'b1;
        end
      end
      ST_ARB: begin
        tok_c   = token_value(ctx_q.idx, ctx_q.ch, ctx_q.dir);
        bit1_d  = tok_c;
        bit0_d  = ~tok_c;
        state_d = ST_TOK_SET;
      end
      ST_TOK_SET: state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (ack_s) begin
          bit0_d  = 1'b0;
          bit1_d  = 1'b0;
          state_d = ST_TOK_CLR;
        end else if (tmo_hit) begin
          bit0_d  = 1'b0;
          bit1_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_TOK_CLR: state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!ack_s) begin
          state_d = ST_NEXT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_NEXT: begin
        if (ctx_q.idx == TOK_FE) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          ctx_d.idx = tok_idx_t'(ctx_q.idx + 3'd1);
          tok_c     = token_value(ctx_d.idx, ctx_q.ch, ctx_q.dir);
          bit1_d    = tok_c;
          bit0_d    = ~tok_c;
          state_d   = ST_TOK_SET;
        end
      end
      ST_DONE, ST_ERR: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        bit0_d  = 1'b0;
        bit1_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctx_q    <= '0;
      prio_q   <= 1'b0;
      grant    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bit0_out <= 1'b0;
      bit1_out <= 1'b0;
    end else begin
      ctx_q    <= ctx_d;
      prio_q   <= prio_d;
      grant    <= grant_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      bit0_out <= bit0_d;
      bit1_out <= bit1_d;
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: directed scenarios plus randomized frames
// checked against a token-list / round-robin reference model.
module tb_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req, dir, grant;
  logic       ack, bit0_out, bit1_out, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int both_hi = 0, grant_cnt = 0, done_cnt = 0, err_cnt = 0, bad_grant = 0;
  logic model_prio;

  always #5 clk = ~clk;

  frame_scheduler #(.TIMEOUT_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .dir      (dir),
    .grant    (grant),
    .ack      (ack),
    .bit0_out (bit0_out),
    .bit1_out (bit1_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always @(negedge clk) begin
    if (bit0_out && bit1_out) both_hi <= both_hi + 1;
    if (grant != 2'b00)       grant_cnt <= grant_cnt + 1;
    if (grant == 2'b11)       bad_grant <= bad_grant + 1;
    if (done)                 done_cnt <= done_cnt + 1;
    if (err)                  err_cnt <= err_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // which: 0 grant seen, 1 a rail high, 2 both rails low, 3 done pulse
  task automatic wait_sig(input int which, input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      case (which)
        0:       ok = (grant != 2'b00);
        1:       ok = bit0_out | bit1_out;
        2:       ok = !(bit0_out | bit1_out);
        default: ok = done;
      endcase
    end
  endtask

  function automatic int pick_ch(input logic [1:0] r);
    if (r == 2'b11) return model_prio ? 1 : 0;
    return r[1] ? 1 : 0;
  endfunction

  task automatic run_frame(input int exp_ch, input logic exp_dir, input bit chk_lat,
                           input bit clear_req, input bit ack_pre, input int abort_tok,
                           input int long_tok);
    int   cyc, gc0, dc0, dly;
    bit   ok;
    logic [4:0] toks;
    gc0  = grant_cnt;
    dc0  = done_cnt;
    toks = {1'b1, exp_dir, 1'b0, logic'(exp_ch == 1), 1'b1};
    wait_sig(0, 40, cyc, ok);
    check("grant_seen", 32'(ok), 1);
    if (!ok) return;
    if (chk_lat) check("grant_latency", cyc, 1);
    check("grant_onehot", 32'(grant), (exp_ch == 1) ? 2 : 1);
    check("busy_at_grant", 32'(busy), 1);
    model_prio = (exp_ch == 0);
    if (clear_req) begin
      req = 2'b00;
      dir = 2'($urandom);
    end
    for (int t = 0; t < 5; t++) begin
      wait_sig(1, 20, cyc, ok);
      check($sformatf("tok%0d_rise", t), 32'(ok), 1);
      if (!ok) return;
      if (t == 0 && chk_lat) check("rail_latency", cyc, 1);
      check($sformatf("tok%0d_rails", t), 32'({bit1_out, bit0_out}), toks[t] ? 2 : 1);
      if (t == abort_tok) begin
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("reset_rails", 32'({bit1_out, bit0_out}), 0);
        check("reset_busy", 32'(busy), 0);
        ack = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
        model_prio = 1'b0;
        return;
      end
      dly = (t == long_tok) ? 1000 : int'($urandom_range(0, 3));
      if (!(ack_pre && t == 0)) begin
        repeat (dly) @(negedge clk);
        ack = 1'b1;
      end
      wait_sig(2, 20, cyc, ok);
      check($sformatf("tok%0d_fall", t), 32'(ok), 1);
      if (!ok) return;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack = 1'b0;
    end
    wait_sig(3, 20, cyc, ok);
    check("done_seen", 32'(ok), 1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 0);
    check("done_one_cycle", 32'(done), 0);
    check("grant_pulses", grant_cnt - gc0, 1);
    check("done_pulses", done_cnt - dc0, 1);
  endtask

  initial begin
    logic [1:0] r, d;
    int         ch;
    reset_n    = 1'b0;
    req        = 2'b00;
    dir        = 2'b00;
    ack        = 1'b0;
    model_prio = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_rails", 32'({bit1_out, bit0_out}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_no_grant", 32'(grant), 0);

    // Single Ch1 request, dir bit 1 -> tokens 1,0,0,1,1
    req = 2'b01; dir = 2'b01;
    run_frame(0, 1'b1, 1'b1, 1'b1, 1'b0, 5, -1);

    // Both requesting: Ch2 is due after a Ch1 grant; then Ch1
    req = 2'b11; dir = 2'b10;
    run_frame(pick_ch(req), 1'b1, 1'b1, 1'b0, 1'b0, 5, -1);
    run_frame(pick_ch(req), 1'b0, 1'b1, 1'b1, 1'b0, 5, -1);

    // Held 11 from a fresh pointer favouring Ch2 (last grant Ch1): Ch2 then Ch1
    req = 2'b11; dir = 2'b10;
    ch  = pick_ch(req);
    run_frame(ch, dir[ch], 1'b1, 1'b0, 1'b0, 5, -1);
    ch  = pick_ch(req);
    run_frame(ch, dir[ch], 1'b1, 1'b1, 1'b0, 5, -1);

    // Ack already high before the first token
    ack = 1'b1;
    repeat (3) @(negedge clk);
    req = 2'b10; dir = 2'b11;
    run_frame(1, 1'b1, 1'b1, 1'b1, 1'b1, 5, -1);

    // Reset during the DIR token; Ch1 regains priority afterwards
    req = 2'b01; dir = 2'b00;
    run_frame(0, 1'b0, 1'b1, 1'b1, 1'b0, 5, -1);
    req = 2'b11; dir = 2'b10;
    run_frame(pick_ch(req), 1'b1, 1'b1, 1'b0, 1'b0, 3, -1);
    run_frame(0, 1'b0, 1'b1, 1'b0, 1'b0, 5, -1);
    run_frame(1, 1'b1, 1'b1, 1'b1, 1'b0, 5, -1);

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      r   = 2'($urandom_range(1, 3));
      d   = 2'($urandom);
      req = r;
      dir = d;
      ch  = pick_ch(r);
      run_frame(ch, d[ch], 1'b1, 1'b1, 1'b0, 5, -1);
    end

`ifdef ACK_TIMEOUT_EN
    begin
      int cyc;
      bit ok;
      req = 2'b01;
      wait_sig(1, 20, cyc, ok);
      check("tmo_rise", 32'(ok), 1);
      req = 2'b00;
      repeat (8) @(negedge clk);
      check("tmo_err_early", 32'(err), 0);
      @(negedge clk);
      check("tmo_err", 32'(err), 1);
      check("tmo_no_done", 32'(done), 0);
      check("tmo_rails", 32'({bit1_out, bit0_out}), 0);
      @(negedge clk);
      check("tmo_err_once", 32'(err), 0);
      check("tmo_busy", 32'(busy), 0);
      model_prio = 1'b1;
    end
`else
    // Very slow receiver: no timeout exists, frame must still complete
    req = 2'b10; dir = 2'b10;
    run_frame(1, 1'b1, 1'b1, 1'b1, 1'b0, 5, 2);
    check("no_err_pulses", err_cnt, 0);
`endif

    check("rails_never_both", both_hi, 0);
    check("grant_never_both", bad_grant, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ack-wait limit in clk cycles per handshake phase; used only when ACK_TIMEOUT_EN is defined.
REQ-002 Parameter SYNC_STAGES, default 2: flop depth of the ack synchronizer; legal values 2..3.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous assert, active-low reset.
REQ-005 req  in  2  per-requester frame request, level; bit0 = Ch1, bit1 = Ch2; held until granted.
REQ-006 dir  in  2  per-requester direction; 1 = Up, 0 = Down; sampled at grant.
REQ-007 grant  out  1x2  one-cycle pulse on the granted requester's bit.
REQ-008 ack  in  1  receiver acknowledge, asynchronous, four-phase.
REQ-009 bit0_out  out  1  dual-rail "0" rail.
REQ-010 bit1_out  out  1  dual-rail "1" rail.
REQ-011 busy  out  1  high from grant until DONE or ERR is exited.
REQ-012 done  out  1  one-cycle pulse on frame completion.
REQ-013 err  out  1  one-cycle pulse on ack timeout; tied 0 without ACK_TIMEOUT_EN.

Function
REQ-014 A frame is five tokens in this fixed order: FS = 1, CH = granted index (0 = Ch1, 1 = Ch2), X0 = 0, DIR = latched dir bit, FE = 1.
REQ-015 Token value 0 drives bit0_out; value 1 drives bit1_out; both rails are never high in the same cycle.
REQ-016 FSM states: IDLE, ARB, TOK_SET, WAIT_HI, TOK_CLR, WAIT_LO, NEXT, DONE, ERR.
REQ-017 IDLE -> ARB when any req bit is high; otherwise stay in IDLE.
REQ-018 ARB: round-robin; if both requests are high, grant the requester not granted last; after reset, Ch1 has priority.
REQ-019 ARB pulses grant, latches the channel index and dir, sets the token index to 0, asserts busy, then -> TOK_SET.
REQ-020 TOK_SET drives the rail for the current token, then -> WAIT_HI.
REQ-021 WAIT_HI holds the rail until synchronized ack = 1, then -> TOK_CLR.
REQ-022 TOK_CLR drops both rails, then -> WAIT_LO.
REQ-023 WAIT_LO waits until synchronized ack = 0, then -> NEXT.
REQ-024 NEXT -> TOK_SET with the token index incremented, or -> DONE after token index 4; the 3-bit index never wraps.
REQ-025 DONE pulses done, deasserts busy, then -> IDLE; a pending req is arbitrated on the following cycle.
REQ-026 Latency: req high in IDLE -> grant 1 cycle later -> rail high 2 cycles after req.
REQ-027 A req deasserted after grant does not abort the frame; req changes mid-frame are ignored until IDLE.
REQ-028 If ack is already high in TOK_SET, the rail is still driven for at least one cycle before TOK_CLR.

Reset
REQ-029 reset_n low: FSM = IDLE, rails = 0, grant = 0, busy = 0, done = 0, err = 0, round-robin pointer = Ch1, synchronizer flops = 0, timeout counter = 0.
REQ-030 Reset mid-frame drops both rails immediately (asynchronously); no partial frame resumes after release.

Configuration
REQ-031 Macro ACK_TIMEOUT_EN defined: a counter clears on entry to WAIT_HI or WAIT_LO; when it reaches TIMEOUT_CYCLES, the FSM drops both rails, goes to ERR, pulses err, deasserts busy, and returns to IDLE; done is not pulsed.
REQ-032 Macro ACK_TIMEOUT_EN undefined: no counter is built, WAIT states wait indefinitely, and err is constant 0.

Structure
REQ-033 Shared package frame_pkg holds the FSM state enum, the token index constants (TOK_FS..TOK_FE) and the fixed token value table.
REQ-034 One sub-module, ack_sync: a SYNC_STAGES-deep synchronizer with asynchronous reset to 0; no other hierarchy.

Verification
REQ-035 req=01, dir=01, responder echoes ack after 3 cycles -> rail sequence 1,0,0,1,1 (bit1,bit0,bit0,bit1,bit1), one grant[0] pulse, one done pulse.
REQ-036 req=11 held for two frames, dir=10 -> first frame CH = 0, DIR = 0; second frame CH = 1, DIR = 1; grants alternate 01 then 10.
REQ-037 ack stuck high before TOK_SET -> rail is high for at least 1 cycle, rails are never both high, and the frame completes once ack cycles.
REQ-038 reset_n pulsed low during WAIT_HI of the DIR token -> rails = 0 immediately, busy = 0, the next frame starts with FS, and Ch1 has priority.
REQ-039 ACK_TIMEOUT_EN defined with TIMEOUT_CYCLES = 8, ack never rises -> err pulses exactly once 8 cycles after WAIT_HI entry, no done pulse, FSM returns to IDLE.
REQ-040 ACK_TIMEOUT_EN undefined, ack delayed 1000 cycles -> no err, and the frame completes normally.
